// File: rtl/coin_pkg.sv
// Shared coin codes and acceptor state encoding.
// Coin codes match the vending FSM's coin input.
package coin_pkg;

   typedef logic [1:0] coin_t;

   localparam coin_t COIN_NONE = 2'b00;
   localparam coin_t COIN_5    = 2'b01;
   localparam coin_t COIN_10   = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REJECT  = 2'd2,
      JAM     = 2'd3
   } state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Chute sensor / inhibit inputs and coin, reject, jam outputs of the acceptor.
// The master side drives the sensor; the slave side is the acceptor.
interface coin_acceptor_if;
   import coin_pkg::*;

   logic  sense;
   logic  inhibit;
   coin_t coin;
   logic  reject;
   logic  jam;

   modport master (output sense, output inhibit, input coin, input reject, input jam);
   modport slave  (input sense, input inhibit, output coin, output reject, output jam);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, synchronous reset to 0.
// Output lags the input by two clock edges.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/coin_acceptor.sv
// Coin validator: measures synchronised sensor pulse width, classifies it into a
// one-cycle coin code, or pulses the reject gate, or flags a stuck sensor as jam.
module coin_acceptor
   import coin_pkg::*;
#(
   parameter int unsigned W5_MIN        = 4,
   parameter int unsigned W5_MAX        = 8,
   parameter int unsigned W10_MIN       = 12,
   parameter int unsigned W10_MAX       = 20,
   parameter int unsigned JAM_LIMIT     = 64,
   parameter int unsigned REJECT_CYCLES = 8,
   parameter int unsigned CNT_W         = 7
) (
   input  logic            i_clk,
   input  logic            i_rst,
   coin_acceptor_if.slave  io_bus
);
   localparam int unsigned RC_W = $clog2(REJECT_CYCLES + 1);

   logic              w_sync;
   logic              w_rise;
   logic              w_in5;
   logic              w_in10;
   logic [CNT_W-1:0]  w_cnt_inc;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [RC_W-1:0]   r_rcnt, w_rcnt_nxt;
   logic              r_prev;
   coin_t             r_coin, w_coin_nxt;
   logic              r_reject, w_reject_nxt;
   logic              r_jam, w_jam_nxt;

   sync_2ff u_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (io_bus.sense),
      .o_q   (w_sync)
   );

   assign w_rise    = w_sync & ~r_prev;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_in5     = (r_cnt >= CNT_W'(W5_MIN))  && (r_cnt <= CNT_W'(W5_MAX));
   assign w_in10    = (r_cnt >= CNT_W'(W10_MIN)) && (r_cnt <= CNT_W'(W10_MAX));

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rcnt_nxt   = r_rcnt;
      w_coin_nxt   = COIN_NONE;
      w_reject_nxt = 1'b0;
      w_jam_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt = MEASURE;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         MEASURE: begin
            if (w_sync) begin
               // Counter stops at JAM_LIMIT because the FSM leaves MEASURE there.
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CNT_W'(JAM_LIMIT)) begin
                  w_state_nxt = JAM;
                  w_jam_nxt   = 1'b1;
               end
            end else if (!io_bus.inhibit && w_in5) begin
               w_state_nxt = IDLE;
               w_coin_nxt  = COIN_5;
            end else if (!io_bus.inhibit && w_in10) begin
               w_state_nxt = IDLE;
               w_coin_nxt  = COIN_10;
            end else begin
               w_state_nxt  = REJECT;
               w_reject_nxt = 1'b1;
               w_rcnt_nxt   = RC_W'(REJECT_CYCLES - 1);
            end
         end
         REJECT: begin
            if (r_rcnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_rcnt_nxt   = r_rcnt - 1'b1;
               w_reject_nxt = 1'b1;
            end
         end
         JAM: begin
            if (!w_sync) begin
               w_state_nxt = IDLE;
            end else begin
               w_jam_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rcnt   <= '0;
         r_prev   <= 1'b0;
         r_coin   <= COIN_NONE;
         r_reject <= 1'b0;
         r_jam    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rcnt   <= w_rcnt_nxt;
         r_prev   <= w_sync;
         r_coin   <= w_coin_nxt;
         r_reject <= w_reject_nxt;
         r_jam    <= w_jam_nxt;
      end
   end

   assign io_bus.coin   = r_coin;
   assign io_bus.reject = r_reject;
   assign io_bus.jam    = r_jam;
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a pulse-scheduling model checked every cycle,
// plus hand-computed counts of coin strobes, reject and jam cycles per scenario.
module tb_coin_acceptor;
   import coin_pkg::*;

   localparam int W5_MIN = 4, W5_MAX = 8, W10_MIN = 12, W10_MAX = 20;
   localparam int JAM_LIMIT = 64, REJECT_CYCLES = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coin_acceptor_if bus ();

   coin_acceptor dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   int checks = 0;
   int failures = 0;

   // Model state: cycle index, sensor seen two edges late, and scheduled outputs.
   int    cyc = 0;
   bit    m1, m2, prev, meas, jamming, mvalid;
   int    width, rej_left, busy_end;
   coin_t e_coin;
   bit    e_rej, e_jam;

   always @(posedge clk) begin : model
      bit s;
      cyc++;
      if (rej_left > 0) rej_left--;
      e_coin = COIN_NONE;
      e_jam  = 1'b0;
      if (rst) begin
         m1 = 0; m2 = 0; prev = 0; meas = 0; jamming = 0;
         rej_left = 0; busy_end = cyc; mvalid = 1;
      end else begin
         s = m2;
         if (jamming) begin
            if (!s) begin
               jamming = 0;
               busy_end = cyc;
            end else begin
               e_jam = 1'b1;
            end
         end else if (meas) begin
            if (s) begin
               width++;
               if (width >= JAM_LIMIT) begin
                  meas = 0; jamming = 1; e_jam = 1'b1;
               end
            end else begin
               meas = 0;
               if (!bus.inhibit && width >= W5_MIN && width <= W5_MAX) begin
                  e_coin = COIN_5; busy_end = cyc;
               end else if (!bus.inhibit && width >= W10_MIN && width <= W10_MAX) begin
                  e_coin = COIN_10; busy_end = cyc;
               end else begin
                  rej_left = REJECT_CYCLES; busy_end = cyc + REJECT_CYCLES;
               end
            end
         end else if (cyc > busy_end && s && !prev) begin
            meas = 1; width = 1;
         end
         prev = s; m2 = m1; m1 = bus.sense;
      end
      e_rej = (rej_left > 0);
   end

   always @(negedge clk) begin
      if (mvalid) begin
         checks++;
         if (bus.coin !== e_coin || bus.reject !== e_rej || bus.jam !== e_jam) begin
            failures++;
            $display("FAIL cycle_model cyc=%0d coin=%b want %b reject=%b want %b jam=%b want %b",
                     cyc, bus.coin, e_coin, bus.reject, e_rej, bus.jam, e_jam);
         end
      end
   end

   int    ncoin, nrej, njam, coin_cyc, n_edge;
   coin_t last_code;

   task automatic clr();
      ncoin = 0; nrej = 0; njam = 0; coin_cyc = 0; last_code = COIN_NONE;
   endtask

   task automatic step();
      @(negedge clk);
      if (bus.coin !== COIN_NONE) begin
         ncoin++; last_code = bus.coin; coin_cyc = cyc;
      end
      if (bus.reject === 1'b1) nrej++;
      if (bus.jam === 1'b1) njam++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic pulse(input int w, input bit inh);
      clr();
      bus.inhibit = inh;
      bus.sense = 1'b1;
      repeat (w) step();
      bus.sense = 1'b0;
      n_edge = cyc + 1;
      repeat (30) step();
      bus.inhibit = 1'b0;
   endtask

   int    widths [8] = '{6, 3, 10, 25, 4, 8, 12, 20};
   int    codes  [8] = '{1, 0, 0, 0, 1, 1, 2, 2};
   int    rejs   [8] = '{0, 8, 8, 8, 0, 0, 0, 0};

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus.sense = 1'b0;
      bus.inhibit = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      clr();
      repeat (10) step();
      chk("reset_coins", ncoin, 0);
      chk("reset_reject", nrej, 0);
      chk("reset_jam", njam, 0);

      for (int i = 0; i < 8; i++) begin
         pulse(widths[i], 1'b0);
         chk($sformatf("w%0d_coins", widths[i]), ncoin, (codes[i] != 0) ? 1 : 0);
         chk($sformatf("w%0d_reject", widths[i]), nrej, rejs[i]);
         chk($sformatf("w%0d_jam", widths[i]), njam, 0);
         if (codes[i] != 0) begin
            chk($sformatf("w%0d_code", widths[i]), int'(last_code), codes[i]);
            chk($sformatf("w%0d_latency", widths[i]), coin_cyc - n_edge, 2);
         end
      end

      clr();
      bus.sense = 1'b1; repeat (15) step();
      bus.sense = 1'b0; repeat (2) step();
      bus.sense = 1'b1; repeat (15) step();
      bus.sense = 1'b0; repeat (30) step();
      chk("b2b_coins", ncoin, 2);
      chk("b2b_code", int'(last_code), 2);
      chk("b2b_reject", nrej, 0);

      clr();
      bus.inhibit = 1'b1;
      bus.sense = 1'b1; repeat (6) step();
      bus.sense = 1'b0; repeat (3) step();
      bus.sense = 1'b1; repeat (3) step();
      bus.sense = 1'b0; repeat (30) step();
      bus.inhibit = 1'b0;
      chk("inhibit_coins", ncoin, 0);
      chk("inhibit_reject", nrej, 8);

      clr();
      bus.sense = 1'b1; repeat (100) step();
      bus.sense = 1'b0; repeat (30) step();
      chk("jam_cycles", njam, 37);
      chk("jam_coins", ncoin, 0);
      chk("jam_reject", nrej, 0);

      clr();
      bus.sense = 1'b1; repeat (12) step();
      rst = 1'b1; step();
      rst = 1'b0; repeat (2) step();
      bus.sense = 1'b0; repeat (30) step();
      chk("rst_mid_coins", ncoin, 0);
      chk("rst_mid_reject", nrej, 8);
      chk("rst_mid_jam", njam, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
